pc_sequencer: RTL and testbench

- Program-counter and branch-resolution unit at the consuming end of the control-block interface.
- Receives branchEq/Neq/Lt/Gt/Lte/Gte and jump strobes plus ALU compare flags, resolves taken/not-taken, and produces the next instruction address.
- Issues one bubble cycle after every redirect, and handles stall and halt.
- Sits between the control block / ALU and instruction memory.

---
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : program counter, branch resolution, redirect bubble, stall/halt.
// Optional taken/not-taken counters under PC_SEQUENCER_BRANCH_COUNT_EN. Rev 1.0
// ============================================================================
module pc_sequencer #(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                halt,
  input  logic                branchEq,
  input  logic                branchNeq,
  input  logic                branchLt,
  input  logic                branchGt,
  input  logic                branchLte,
  input  logic                branchGte,
  input  logic                jump,
  input  logic                aluZero,
  input  logic                aluLt,
  input  logic [PC_WIDTH-1:0] branchOffset,
  input  logic [PC_WIDTH-1:0] jumpTarget,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pcLink,
  output logic                instrValid,
  output logic                branchTaken,
`ifdef PC_SEQUENCER_BRANCH_COUNT_EN
  output logic [15:0]         takenCount,
  output logic [15:0]         notTakenCount,
`endif
  output logic                ctrlError
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic                taken_nxt, error_nxt;
  logic                any_branch, cond_true, multi_strobe;

  // Several asserted branch strobes resolve as the OR of their conditions.
  assign cond_true = (branchEq  &  aluZero)
                   | (branchNeq & ~aluZero)
                   | (branchLt  &  aluLt)
                   | (branchGt  & ~aluLt & ~aluZero)
                   | (branchLte & (aluLt | aluZero))
                   | (branchGte & ~aluLt);

  assign any_branch   = branchEq | branchNeq | branchLt | branchGt | branchLte | branchGte;
  assign multi_strobe = $countones({jump, branchEq, branchNeq, branchLt,
                                    branchGt, branchLte, branchGte}) > 1;

  assign pcLink     = pc + PC_WIDTH'(1);
  assign instrValid = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    taken_nxt = 1'b0;
    error_nxt = 1'b0;
    if (!stall) begin
      case (state)
        ST_BOOT:     state_nxt = ST_RUN;
        ST_REDIRECT: state_nxt = ST_RUN;
        ST_HALTED:   state_nxt = ST_HALTED;
        ST_RUN: begin
          error_nxt = multi_strobe;
          if (halt) begin
            state_nxt = ST_HALTED;
          end else if (jump) begin
            pc_nxt    = jumpTarget;
            taken_nxt = 1'b1;
            state_nxt = ST_REDIRECT;
          end else if (any_branch && cond_true) begin
            pc_nxt    = pc + branchOffset;
            taken_nxt = 1'b1;
            state_nxt = ST_REDIRECT;
          end else begin
            pc_nxt = pc + PC_WIDTH'(1);
          end
        end
        default: state_nxt = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      branchTaken <= 1'b0;
      ctrlError   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      branchTaken <= taken_nxt;
      ctrlError   <= error_nxt;
    end
  end

`ifdef PC_SEQUENCER_BRANCH_COUNT_EN
  logic resolve;

  // Only conditional branches actually decided count; jump and halt pre-empt them.
  assign resolve = (state == ST_RUN) && !stall && !halt && !jump && any_branch;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      takenCount    <= 16'h0000;
      notTakenCount <= 16'h0000;
    end else if (resolve) begin
      if (cond_true && takenCount != 16'hFFFF) begin
        takenCount <= takenCount + 16'h0001;
      end
      if (!cond_true && notTakenCount != 16'hFFFF) begin
        notTakenCount <= notTakenCount + 16'h0001;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// tb_pc_sequencer : vector table, hand-written corner sequences and a randomized
// run against a behavioural model of the sequencer.
module tb_pc_sequencer;

  localparam logic [15:0] RV = 16'h0010;
  localparam logic [5:0] BEQ = 6'b100000, BNE = 6'b010000, BLT = 6'b001000,
                         BGT = 6'b000100, BLE = 6'b000010, BGE = 6'b000001;
  localparam int M_BOOT = 0, M_RUN = 1, M_BUBBLE = 2, M_HALT = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall, halt, jump, aluZero, aluLt;
  logic [5:0]  br;
  logic [15:0] branchOffset, jumpTarget;
  logic [15:0] pc, pcLink;
  logic        instrValid, branchTaken, ctrlError;
  int          opa, opb;

  int total = 0;
  int bad   = 0;

  // Behavioural model
  int   m_pc, m_mode;
  logic m_taken, m_err;

  pc_sequencer #(.PC_WIDTH(16), .RESET_VECTOR(RV)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .halt(halt),
    .branchEq(br[5]), .branchNeq(br[4]), .branchLt(br[3]),
    .branchGt(br[2]), .branchLte(br[1]), .branchGte(br[0]),
    .jump(jump), .aluZero(aluZero), .aluLt(aluLt),
    .branchOffset(branchOffset), .jumpTarget(jumpTarget),
    .pc(pc), .pcLink(pcLink), .instrValid(instrValid),
    .branchTaken(branchTaken), .ctrlError(ctrlError)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       s, h, j;
    logic [5:0] b;
    int         a, bb;
    logic [15:0] off, tgt, e_pc;
    logic       e_v, e_t, e_e;
  } vec_t;

  vec_t tbl[27];

  task automatic drive(input logic s, h, j, input logic [5:0] b, input int a, bb,
                       input logic [15:0] off, tgt);
    stall = s; halt = h; jump = j; br = b; opa = a; opb = bb;
    aluZero = (a == bb); aluLt = (a < bb);
    branchOffset = off; jumpTarget = tgt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_pc,
                           input logic e_v, e_t, e_e);
    check({tag, " pc"}, 32'(pc), 32'(e_pc));
    check({tag, " pcLink"}, 32'(pcLink), 32'((e_pc + 16'd1) & 16'hFFFF));
    check({tag, " valid"}, 32'(instrValid), 32'(e_v));
    check({tag, " taken"}, 32'(branchTaken), 32'(e_t));
    check({tag, " err"}, 32'(ctrlError), 32'(e_e));
  endtask

  task automatic model_reset;
    m_pc = int'(RV); m_mode = M_BOOT; m_taken = 0; m_err = 0;
  endtask

  // Branch outcome derived from the operand relation the ALU flags describe.
  task automatic model_step;
    int  n;
    bit  hit;
    m_taken = 0; m_err = 0;
    if (!stall) begin
      if (m_mode == M_BOOT || m_mode == M_BUBBLE) m_mode = M_RUN;
      else if (m_mode == M_RUN) begin
        n = int'(jump) + $countones(br);
        m_err = (n > 1);
        hit = (br[5] && opa == opb) || (br[4] && opa != opb) || (br[3] && opa < opb) ||
              (br[2] && opa > opb) || (br[1] && opa <= opb) || (br[0] && opa >= opb);
        if (halt) m_mode = M_HALT;
        else if (jump) begin
          m_pc = int'(jumpTarget); m_taken = 1; m_mode = M_BUBBLE;
        end else if (hit) begin
          m_pc = (m_pc + int'($signed(branchOffset))) & 32'hFFFF;
          m_taken = 1; m_mode = M_BUBBLE;
        end else m_pc = (m_pc + 1) & 32'hFFFF;
      end
    end
  endtask

  initial begin
    //         s  h  j  br    a  b  off       tgt       pc        v  t  e
    tbl[0]  = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h0010, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h0011, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h0012, 1, 0, 0};
    tbl[3]  = '{0, 0, 1, 6'd0, 0, 0, 16'h0000, 16'h0020, 16'h0020, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h0020, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, BEQ,  2, 2, 16'hFFFC, 16'h0000, 16'h001C, 0, 1, 0};
    tbl[6]  = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h001C, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h001D, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, BGT,  3, 3, 16'h0010, 16'h0000, 16'h001E, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, BGT,  5, 3, 16'h0010, 16'h0000, 16'h002E, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h002E, 1, 0, 0};
    tbl[11] = '{0, 0, 1, BNE,  1, 2, 16'h0000, 16'h0100, 16'h0100, 0, 1, 1};
    tbl[12] = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h0100, 1, 0, 0};
    tbl[13] = '{1, 0, 1, BEQ,  1, 1, 16'h0000, 16'h0200, 16'h0100, 1, 0, 0};
    tbl[14] = '{0, 0, 0, BLT,  1, 2, 16'hFEFF, 16'h0000, 16'hFFFF, 0, 1, 0};
    tbl[15] = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0};
    tbl[17] = '{0, 0, 1, 6'd0, 0, 0, 16'h0000, 16'hFFFE, 16'hFFFE, 0, 1, 0};
    tbl[18] = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'hFFFE, 1, 0, 0};
    tbl[19] = '{0, 0, 0, BGE,  3, 3, 16'h0003, 16'h0000, 16'h0001, 0, 1, 0};
    tbl[20] = '{1, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0};
    tbl[21] = '{1, 0, 1, 6'd0, 0, 0, 16'h0000, 16'h0300, 16'h0001, 0, 0, 0};
    tbl[22] = '{1, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0};
    tbl[23] = '{0, 0, 0, BLE,  4, 3, 16'h0040, 16'h0000, 16'h0001, 1, 0, 0};
    tbl[24] = '{0, 1, 1, BLE,  2, 3, 16'h0000, 16'h0500, 16'h0001, 0, 0, 1};
    tbl[25] = '{0, 0, 1, 6'd0, 0, 0, 16'h0000, 16'h0600, 16'h0001, 0, 0, 0};
    tbl[26] = '{0, 0, 0, 6'd0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0};

    drive(0, 0, 0, 6'd0, 0, 0, 16'h0, 16'h0);
    reset_n = 1'b0;
    #12;
    check_all("reset", RV, 0, 0, 0);
    reset_n = 1'b1;

    // BOOT holds pc, RUN walks, redirects, wraps, stalled bubble, halt.
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].s, tbl[i].h, tbl[i].j, tbl[i].b, tbl[i].a, tbl[i].bb,
            tbl[i].off, tbl[i].tgt);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_v, tbl[i].e_t, tbl[i].e_e);
    end

    // Only reset leaves HALTED; reset acts without a clock edge.
    drive(0, 0, 0, 6'd0, 0, 0, 16'h0, 16'h0);
    reset_n = 1'b0;
    #1;
    check_all("halt_exit_reset", RV, 0, 0, 0);
    #1 reset_n = 1'b1;
    tick();
    check_all("reboot_run", RV, 1, 0, 0);

    // Reset arriving in the middle of a stalled bubble.
    drive(0, 0, 1, 6'd0, 0, 0, 16'h0, 16'h0040);
    tick();
    check_all("seq_jump", 16'h0040, 0, 1, 0);
    drive(1, 0, 1, BEQ, 1, 1, 16'h0004, 16'h0080);
    tick();
    check_all("seq_stall1", 16'h0040, 0, 0, 0);
    tick();
    check_all("seq_stall2", 16'h0040, 0, 0, 0);
    reset_n = 1'b0;
    #2;
    check_all("seq_midstall_reset", RV, 0, 0, 0);
    reset_n = 1'b1;

    // Randomized run against the model.
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all($sformatf("rnd%0d reset", c), 16'(m_pc), 0, 0, 0);
        #1 reset_n = 1'b1;
      end
      drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 1,
            $urandom_range(0, 99) < 10,
            {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0},
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom));
      tick();
      model_step();
      check_all($sformatf("rnd%0d", c), 16'(m_pc), m_mode == M_RUN, m_taken, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
